axis_labcontrol_rx_multi: RTL
=============================

AXIS_LABCONTROL_RX_MULTI -- requirements
Module: axis_labcontrol_rx_multi

Interface
REQ-001 Parameter AXIS_DATA_WIDTH, default 16: output sample width; legal range 8..32.
REQ-002 Parameter NUM_CHANNELS, default 4: number of consecutive bus addresses served; legal range 1..16.
REQ-003 Parameter BASE_ADDRESS, default 'hF0: first served address; BASE_ADDRESS+NUM_CHANNELS-1 SHALL be at most 'hFF.
REQ-004 Parameter SUBBUS, default 0: required DIOD[4:2] value.
REQ-005 Parameter FIFO_DEPTH, default 16: buffered words; power of two, 2..256.
REQ-006 Parameter SYNC_STAGES, default 2: synchroniser depth; minimum 2.
REQ-007 Parameter TWOS_COMPL, default 1: 1 sign-extends, 0 zero-extends when AXIS_DATA_WIDTH > 16.
REQ-008 m_axis_aclk  in  1  sole clock; one clock; reset is synchronous and active-high.
REQ-009 m_axis_areset  in  1  synchronous active-high reset.
REQ-010 m_axis_tdata  out  AXIS_DATA_WIDTH  captured sample.
REQ-011 m_axis_tdest  out  4  channel index (address minus BASE_ADDRESS).
REQ-012 m_axis_tvalid  out  1  word available.
REQ-013 m_axis_tready  in  1  downstream accept.
REQ-014 DIOA, DIOB, DIOC, DIOD  in  8 each  asynchronous LabControl bus: data {DIOB,DIOA}, address DIOC, reserved DIOD[7:5], subbus DIOD[4:2], direction DIOD[1], strobe DIOD[0].
REQ-015 overflow  out  1  sticky: at least one word dropped since reset.
REQ-016 drop_count  out  16  saturating count of dropped words.

Function
REQ-017 All 32 bus bits SHALL pass through SYNC_STAGES flops in lockstep so data, address and strobe stay aligned.
REQ-018 A strobe event SHALL be one cycle where the synchronised strobe is 1 and was 0 on the previous cycle.
REQ-019 An event SHALL be accepted only when address is in [BASE_ADDRESS, BASE_ADDRESS+NUM_CHANNELS-1], subbus equals SUBBUS and direction is 0; other events are ignored without side effects.
REQ-020 An accepted event SHALL write {channel, data} into the FIFO on the next clock edge.
REQ-021 Latency: with the FIFO empty, m_axis_tvalid SHALL rise exactly SYNC_STAGES+2 cycles after the first edge sampling DIOD[0]=1.
REQ-022 The FIFO SHALL be first-word-fall-through; tdata/tdest SHALL be stable while tvalid=1 and tready=0.
REQ-023 A word SHALL be transferred and popped on any cycle where tvalid=1 and tready=1.
REQ-024 Full and push: the word SHALL be dropped, overflow set, and drop_count incremented, saturating at 'hFFFF.
REQ-025 Full with push and pop in the same cycle: the push SHALL be accepted and nothing dropped.
REQ-026 Empty: tvalid SHALL be 0, and tdata/tdest SHALL hold their last value.
REQ-027 Width: if AXIS_DATA_WIDTH < 16, tdata SHALL be the LSBs. If greater and TWOS_COMPL=1, bit 15 SHALL be replicated; if TWOS_COMPL=0, tdata SHALL be zero-filled.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be held in a separate counter of width log2(FIFO_DEPTH)+1.

Reset
REQ-029 Reset SHALL force the following values: tvalid=0, tdata=0, tdest=0, overflow=0, drop_count=0, FIFO empty.
REQ-030 Synchroniser and edge-history strobe flops SHALL reset to 1, so a strobe held high across reset release produces no word.
REQ-031 Reset mid-operation SHALL discard buffered words and any event in the synchroniser.

Structure
REQ-032 Bus field positions, the channel-index width (4) and drop_count width SHALL live in shared package axis_labcontrol_pkg.
REQ-033 Storage SHALL be one sub-module, axis_labcontrol_fifo, parameterised by width and depth, with a synchronous active-high reset.

Verification
REQ-034 Bench scenario: write 'h1234 to BASE_ADDRESS+2 with tready=1 -> one beat with tdata='h1234 and tdest=2, tvalid rising SYNC_STAGES+2 cycles after the strobe.
REQ-035 Bench scenario: strobe to address 'h10, to the correct address with subbus 5, and with direction=1 -> no beats, drop_count stays 0.
REQ-036 Bench scenario: tready=0 with FIFO_DEPTH+3 accepted writes -> FIFO_DEPTH beats delivered in order after tready=1, overflow=1, drop_count=3.
REQ-037 Bench scenario: AXIS_DATA_WIDTH=24 with data 'h8001 -> tdata='hFF8001 when TWOS_COMPL=1 and 'h008001 when TWOS_COMPL=0.
REQ-038 Bench scenario: FIFO full, then a simultaneous pop and accepted push -> count unchanged, new word delivered last, drop_count unchanged.
REQ-039 Bench scenario: strobe high through reset release, or reset asserted 1 cycle after a strobe edge -> no beat emitted, all outputs at reset values.

Source files
------------

// File: rtl/axis_labcontrol_pkg.sv
// axis_labcontrol_pkg: LabControl bus field layout and shared widths.
package axis_labcontrol_pkg;
    // Synchronised bus word is {DIOD, DIOC, DIOB, DIOA}
    localparam int BUS_W    = 32;
    localparam int DATA_LSB = 0;
    localparam int ADDR_LSB = 16;
    localparam int STB_BIT  = 24;
    localparam int DIR_BIT  = 25;
    localparam int SUB_LSB  = 26;
    localparam int RSV_LSB  = 29;
    localparam int CH_W     = 4;
    localparam int DROP_W   = 16;
    typedef logic [CH_W-1:0] chan_t;
endpackage

// File: rtl/axis_labcontrol_rx_multi_if.sv
// axis_labcontrol_rx_multi_if: AXI-Stream beat carrying a sample and its channel index.
interface axis_labcontrol_rx_multi_if
    import axis_labcontrol_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) ();
    logic [DATA_WIDTH-1:0] tdata;
    chan_t                 tdest;
    logic                  tvalid;
    logic                  tready;
    modport master (output tdata, tdest, tvalid, input tready);
    modport slave  (input tdata, tdest, tvalid, output tready);
endinterface

// File: rtl/axis_labcontrol_fifo.sv
// axis_labcontrol_fifo: first-word-fall-through FIFO with a registered head word.
module axis_labcontrol_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             pop, push_ok, load;
    // count covers the head register too, so total capacity stays DEPTH
    always_comb begin
        pop     = valid && ready;
        push_ok = push && (count != CW'(DEPTH) || pop);
        drop    = push && !push_ok;
        load    = (count - CW'(valid)) != '0 && (!valid || pop);
    end
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            dout   <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_ok);
            rd_ptr <= rd_ptr + AW'(load);
            count  <= count + CW'(push_ok) - CW'(pop);
            valid  <= load || (valid && !pop);
            if (load) dout <= mem[rd_ptr];
        end
    end
endmodule

// File: rtl/axis_labcontrol_rx_multi.sv
// axis_labcontrol_rx_multi: captures LabControl bus writes to a block of addresses
// and streams them out as AXI-Stream beats tagged with the channel index.
module axis_labcontrol_rx_multi
    import axis_labcontrol_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 16,
    parameter int NUM_CHANNELS    = 4,
    parameter int BASE_ADDRESS    = 'hF0,
    parameter int SUBBUS          = 0,
    parameter int FIFO_DEPTH      = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int TWOS_COMPL      = 1
) (
    input  logic                      m_axis_aclk,
    input  logic                      m_axis_areset,
    input  logic [7:0]                DIOA,
    input  logic [7:0]                DIOB,
    input  logic [7:0]                DIOC,
    input  logic [7:0]                DIOD,
    axis_labcontrol_rx_multi_if.master m_axis,
    output logic                      overflow,
    output logic [DROP_W-1:0]         drop_count
);
    logic [BUS_W-1:0]                  sync [SYNC_STAGES];
    logic [BUS_W-1:0]                  bus_q;
    logic                              prev_q, accept, drop, unused_rsvd;
    logic [7:0]                        addr, off;
    logic [AXIS_DATA_WIDTH-1:0]        ext;
    logic [CH_W+AXIS_DATA_WIDTH-1:0]   dout;
    // Strobe history resets high so a strobe held through reset is not an edge
    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_areset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '1;
            bus_q  <= '1;
            prev_q <= 1'b1;
        end else begin
            sync[0] <= {DIOD, DIOC, DIOB, DIOA};
            for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
            bus_q  <= sync[SYNC_STAGES-1];
            prev_q <= bus_q[STB_BIT];
        end
    end
    always_comb begin
        addr   = bus_q[ADDR_LSB +: 8];
        off    = addr - 8'(BASE_ADDRESS);
        accept = bus_q[STB_BIT] && !prev_q && addr >= 8'(BASE_ADDRESS) &&
                 off < 8'(NUM_CHANNELS) && bus_q[SUB_LSB +: 3] == 3'(SUBBUS) && !bus_q[DIR_BIT];
    end
    assign unused_rsvd = ^bus_q[BUS_W-1:RSV_LSB];
    generate
        if (AXIS_DATA_WIDTH <= 16) begin : g_narrow
            assign ext = bus_q[DATA_LSB +: AXIS_DATA_WIDTH];
        end else begin : g_wide
            assign ext = {{(AXIS_DATA_WIDTH-16){TWOS_COMPL != 0 && bus_q[DATA_LSB+15]}}, bus_q[DATA_LSB +: 16]};
        end
    endgenerate
    axis_labcontrol_fifo #(.WIDTH(CH_W + AXIS_DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (m_axis_aclk),
        .rst   (m_axis_areset),
        .push  (accept),
        .din   ({off[CH_W-1:0], ext}),
        .ready (m_axis.tready),
        .dout  (dout),
        .valid (m_axis.tvalid),
        .drop  (drop)
    );
    assign {m_axis.tdest, m_axis.tdata} = dout;
    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_areset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow   <= 1'b1;
            drop_count <= drop_count + DROP_W'(drop_count != '1);
        end
    end
endmodule
